// File: rtl/branch_direction_predictor.sv
// rtl/branch_direction_predictor.sv - gshare direction predictor with in-flight checkpoint FIFO
module branch_direction_predictor #(
  parameter int PHT_INDEX_WIDTH = 6,
  parameter int GHR_WIDTH       = 6,
  parameter int CKPT_DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_fetch_valid,
  input  logic [31:0]                i_pc,
  input  logic                       i_btb_hit,
  input  logic [25:0]                i_btb_target,
  output logic                       o_ready,
  output logic                       o_pred_taken,
  output logic [31:0]                o_pred_pc,
  output logic                       o_pred_tracked,
  output logic [PHT_INDEX_WIDTH-1:0] o_pht_idx,
  input  logic                       i_res_valid,
  input  logic                       i_res_tracked,
  input  logic                       i_res_taken,
  input  logic                       i_res_mispredict,
  input  logic [PHT_INDEX_WIDTH-1:0] i_res_pht_idx,
  output logic                       o_underflow
);

  localparam int PHT_ENTRIES = 1 << PHT_INDEX_WIDTH;
  localparam int PTR_W       = $clog2(CKPT_DEPTH);
  localparam int CNT_W       = PTR_W + 1;

  logic [1:0]                 pht [PHT_ENTRIES];
  // Only the PHT index is kept per checkpoint: the resolved direction and the
  // mispredict flag arrive from the backend, so the predicted bit is never reread.
  logic [PHT_INDEX_WIDTH-1:0] ckpt_idx [CKPT_DEPTH];
  logic [PTR_W-1:0]           rd_ptr, wr_ptr;
  logic [CNT_W-1:0]           count;
  logic [GHR_WIDTH-1:0]       spec_ghr, commit_ghr, commit_ghr_next;
  logic [PHT_INDEX_WIDTH-1:0] ghr_ext, upd_idx;
  logic                       push, pop, flush, upd_en, underflow_evt;
  logic [1:0]                 upd_old, upd_new;

  // Lookup path: gshare index, direction, next PC and push qualification
  always_comb begin
    ghr_ext                 = '0;
    ghr_ext[GHR_WIDTH-1:0]  = spec_ghr;
    o_pht_idx      = i_pc[PHT_INDEX_WIDTH+1:2] ^ ghr_ext;
    o_pred_taken   = i_btb_hit & pht[o_pht_idx][1];
    o_pred_pc      = o_pred_taken ? {i_pc[31:28], i_btb_target, 2'b00} : i_pc + 32'd4;
    o_ready        = count < CNT_W'(CKPT_DEPTH);
    flush          = i_res_valid & i_res_mispredict;
    o_pred_tracked = i_fetch_valid & i_btb_hit & o_ready & ~flush;
    push           = o_pred_tracked;
  end

  // Resolution path: choose the PHT entry to train and the next committed history
  always_comb begin
    pop             = i_res_valid & i_res_tracked & (count != '0);
    underflow_evt   = i_res_valid & i_res_tracked & (count == '0);
    upd_en          = pop | (i_res_valid & ~i_res_tracked);
    upd_idx         = i_res_tracked ? ckpt_idx[rd_ptr] : i_res_pht_idx;
    upd_old         = pht[upd_idx];
    if (i_res_taken) upd_new = (upd_old == 2'b11) ? 2'b11 : upd_old + 2'b01;
    else             upd_new = (upd_old == 2'b00) ? 2'b00 : upd_old - 2'b01;
    commit_ghr_next = pop ? ((commit_ghr << 1) | GHR_WIDTH'(i_res_taken)) : commit_ghr;
  end

  // PHT training; a same-cycle lookup of the entry sees the old value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < PHT_ENTRIES; i++) pht[i] <= 2'b01;
    end else if (upd_en) begin
      pht[upd_idx] <= upd_new;
    end
  end

  // Checkpoint FIFO storage (contents need no reset; count gates validity)
  always_ff @(posedge clk) begin
    if (push) ckpt_idx[wr_ptr] <= o_pht_idx;
  end

  // FIFO control, both histories and the sticky underflow flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      spec_ghr    <= '0;
      commit_ghr  <= '0;
      o_underflow <= 1'b0;
    end else begin
      commit_ghr <= commit_ghr_next;
      if (underflow_evt) o_underflow <= 1'b1;
      if (flush) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        spec_ghr <= commit_ghr_next;
      end else begin
        if (push) begin
          wr_ptr   <= wr_ptr + 1'b1;
          spec_ghr <= (spec_ghr << 1) | GHR_WIDTH'(o_pred_taken);
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

endmodule

// File: tb/tb_branch_direction_predictor.sv
// tb/tb_branch_direction_predictor.sv - scoreboard bench for branch_direction_predictor
module tb_branch_direction_predictor;

  localparam logic [25:0] TGT = 26'h0100040;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_fetch_valid = 1'b0;
  logic [31:0] i_pc = '0;
  logic        i_btb_hit = 1'b0;
  logic [25:0] i_btb_target = TGT;
  logic        o_ready, o_pred_taken, o_pred_tracked, o_underflow;
  logic [31:0] o_pred_pc;
  logic [5:0]  o_pht_idx;
  logic        i_res_valid = 1'b0, i_res_tracked = 1'b0, i_res_taken = 1'b0, i_res_mispredict = 1'b0;
  logic [5:0]  i_res_pht_idx = '0;

  branch_direction_predictor dut (
    .clk(clk), .rst_n(rst_n),
    .i_fetch_valid(i_fetch_valid), .i_pc(i_pc), .i_btb_hit(i_btb_hit), .i_btb_target(i_btb_target),
    .o_ready(o_ready), .o_pred_taken(o_pred_taken), .o_pred_pc(o_pred_pc),
    .o_pred_tracked(o_pred_tracked), .o_pht_idx(o_pht_idx),
    .i_res_valid(i_res_valid), .i_res_tracked(i_res_tracked), .i_res_taken(i_res_taken),
    .i_res_mispredict(i_res_mispredict), .i_res_pht_idx(i_res_pht_idx),
    .o_underflow(o_underflow)
  );

  always #5 clk = ~clk;

  typedef enum int {S_READY, S_TAKEN, S_PC, S_TRACKED, S_IDX, S_UNDER} sel_t;
  typedef struct {
    int          cyc;
    sel_t        sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cycle = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [31:0] actual(sel_t s);
    case (s)
      S_READY:   return {31'd0, o_ready};
      S_TAKEN:   return {31'd0, o_pred_taken};
      S_PC:      return o_pred_pc;
      S_TRACKED: return {31'd0, o_pred_tracked};
      S_IDX:     return {26'd0, o_pht_idx};
      default:   return {31'd0, o_underflow};
    endcase
  endfunction

  // Monitor: pops every expectation belonging to the current cycle mid-cycle
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] a;
    while (sb.size() > 0 && sb[0].cyc <= cycle) begin
      e = sb.pop_front();
      a = actual(e.sel);
      n_checks++;
      if (a !== e.exp) begin
        n_fail++;
        $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", e.name, a, e.exp, e.cyc);
      end
    end
  end

  task automatic chk(input sel_t s, input logic [31:0] v, input string name);
    exp_t e;
    e.cyc  = cycle;
    e.sel  = s;
    e.exp  = v;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic step(input logic r, input logic fv, input logic [31:0] pc, input logic hit,
                      input logic rv, input logic rtr, input logic rtk, input logic rmp,
                      input logic [5:0] ridx);
    @(posedge clk);
    #1;
    rst_n = r; i_fetch_valid = fv; i_pc = pc; i_btb_hit = hit;
    i_res_valid = rv; i_res_tracked = rtr; i_res_taken = rtk;
    i_res_mispredict = rmp; i_res_pht_idx = ridx;
  endtask

  task automatic fetch(input logic [31:0] pc);
    step(1, 1, pc, 1, 0, 0, 0, 0, 0);
  endtask

  // Resolution while looking up 0x00400010 without fetching (observes PHT[4] when GHR=0)
  task automatic res_look(input logic tr, input logic tk, input logic mp, input logic [5:0] idx);
    step(1, 0, 32'h00400010, 1, 1, tr, tk, mp, idx);
  endtask

  task automatic look(input logic [31:0] pc);
    step(1, 0, pc, 1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int guard;
    // Reset with busy inputs
    step(0, 1, 32'h00400010, 1, 1, 1, 1, 1, 0);
    chk(S_TAKEN, 0, "reset_taken");
    step(0, 1, 32'h00400010, 1, 1, 1, 1, 1, 0);
    chk(S_READY, 1, "reset_ready");
    step(1, 0, 32'hFFFFFFFC, 0, 0, 0, 0, 0, 0);
    chk(S_READY, 1, "post_reset_ready");
    chk(S_TRACKED, 0, "post_reset_tracked");
    chk(S_UNDER, 0, "post_reset_underflow");
    chk(S_PC, 32'h0, "pc_plus4_wrap");

    // First lookup and two pushes at index 4
    fetch(32'h00400010);
    chk(S_TAKEN, 0, "first_taken");
    chk(S_PC, 32'h00400014, "first_pc");
    chk(S_IDX, 4, "first_idx");
    chk(S_TRACKED, 1, "first_tracked");
    fetch(32'h00400010);
    chk(S_IDX, 4, "second_idx");
    chk(S_TRACKED, 1, "second_tracked");

    // Two taken resolutions train PHT[4] 01->10->11; lookups see pre-update value
    res_look(1, 1, 0, 0);
    chk(S_TAKEN, 0, "train1_pre_taken");
    chk(S_UNDER, 0, "train1_underflow");
    res_look(1, 1, 0, 0);
    chk(S_TAKEN, 1, "train2_pre_taken");
    look(32'h00400010);
    chk(S_TAKEN, 1, "trained_taken");
    chk(S_PC, 32'h00400100, "trained_pc");
    chk(S_TRACKED, 0, "no_fetch_tracked");

    // Saturation at 11 then walk down: 11,11,10,01
    res_look(0, 1, 0, 6'd4);
    res_look(0, 1, 0, 6'd4);
    chk(S_TAKEN, 1, "sat_hi_taken");
    res_look(0, 0, 0, 6'd4);
    res_look(0, 0, 0, 6'd4);
    chk(S_TAKEN, 1, "same_cycle_preupdate_10");
    res_look(0, 0, 0, 6'd4);
    chk(S_TAKEN, 0, "after_dec_01");
    // Saturation at 00 then walk up: 00,01,10
    res_look(0, 0, 0, 6'd4);
    res_look(0, 1, 0, 6'd4);
    chk(S_TAKEN, 0, "sat_lo_taken");
    res_look(0, 1, 0, 6'd4);
    chk(S_TAKEN, 0, "same_cycle_preupdate_01");
    look(32'h00400010);
    chk(S_TAKEN, 1, "after_inc_10");

    // Fill the FIFO: four pushes, fifth refused
    for (int i = 0; i < 4; i++) begin
      fetch(32'h00400020);
      chk(S_READY, 1, $sformatf("fill_ready_%0d", i));
      chk(S_TRACKED, 1, $sformatf("fill_tracked_%0d", i));
      chk(S_IDX, 8, $sformatf("fill_idx_%0d", i));
    end
    fetch(32'h00400020);
    chk(S_READY, 0, "full_ready");
    chk(S_TRACKED, 0, "full_tracked");
    step(1, 1, 32'h00400020, 1, 1, 1, 0, 0, 0);
    chk(S_READY, 0, "full_pop_ready");
    chk(S_TRACKED, 0, "full_pop_tracked");
    look(32'h00400020);
    chk(S_READY, 1, "after_pop_ready");

    // Reset mid-operation discards in-flight entries and retrains PHT to 01
    step(0, 1, 32'h00400010, 1, 1, 1, 1, 1, 0);
    look(32'h00400010);
    chk(S_READY, 1, "midreset_ready");
    chk(S_IDX, 4, "midreset_idx");
    chk(S_TAKEN, 0, "midreset_pht");
    chk(S_UNDER, 0, "midreset_underflow");

    // Mispredict flush overrides a same-cycle push
    fetch(32'h00400010);
    chk(S_TRACKED, 1, "mp_push1");
    fetch(32'h00400010);
    chk(S_TRACKED, 1, "mp_push2");
    chk(S_IDX, 4, "mp_push2_idx");
    step(1, 1, 32'h00400010, 1, 1, 1, 1, 1, 0);
    chk(S_TRACKED, 0, "mp_push_dropped");
    chk(S_IDX, 4, "mp_cycle_idx");
    look(32'h00400010);
    chk(S_IDX, 5, "mp_spec_ghr_restored");
    chk(S_READY, 1, "mp_ready");
    chk(S_TAKEN, 0, "mp_idx5_taken");

    // Tracked resolution with empty FIFO: sticky underflow, PHT untouched
    step(1, 0, 32'h00400010, 0, 1, 1, 0, 0, 0);
    chk(S_UNDER, 0, "underflow_not_yet");
    look(32'h00400014);
    chk(S_UNDER, 1, "underflow_set");
    chk(S_IDX, 4, "underflow_ghr_kept");
    chk(S_TAKEN, 1, "underflow_pht_kept");
    chk(S_PC, 32'h00400100, "underflow_pc");
    repeat (3) look(32'h00400014);
    chk(S_UNDER, 1, "underflow_sticky");
    step(0, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    look(32'h00400010);
    chk(S_UNDER, 0, "underflow_cleared");

    // Drain the scoreboard with a bounded wait
    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: actual %0d pending required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_direction_predictor.md
BRANCH_DIRECTION_PREDICTOR -- requirements
Module: branch_direction_predictor

Interface
REQ-001 SHALL have parameter PHT_INDEX_WIDTH, default 6, log2 of pattern-history-table entries.
REQ-002 SHALL have parameter GHR_WIDTH, default 6 (<= PHT_INDEX_WIDTH), global history bits.
REQ-003 SHALL have parameter CKPT_DEPTH, default 4 (power of 2), in-flight tracked-branch FIFO depth.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port i_fetch_valid  input  1  fetch presents a PC this cycle.
REQ-007 SHALL have port i_pc  input  32  current fetch PC.
REQ-008 SHALL have port i_btb_hit  input  1  BTB hit for i_pc.
REQ-009 SHALL have port i_btb_target  input  26  BTB target, word address.
REQ-010 SHALL have port o_ready  output  1  FIFO can accept a tracked prediction.
REQ-011 SHALL have port o_pred_taken  output  1  predicted direction.
REQ-012 SHALL have port o_pred_pc  output  32  predicted next PC.
REQ-013 SHALL have port o_pred_tracked  output  1  prediction pushed into FIFO this cycle.
REQ-014 SHALL have port o_pht_idx  output  PHT_INDEX_WIDTH  PHT index used for i_pc.
REQ-015 SHALL have port i_res_valid  input  1  a branch resolves this cycle.
REQ-016 SHALL have port i_res_tracked  input  1  resolving branch was tracked (o_pred_tracked piped).
REQ-017 SHALL have port i_res_taken  input  1  actual direction.
REQ-018 SHALL have port i_res_mispredict  input  1  fetch path was wrong; pipeline flushes.
REQ-019 SHALL have port i_res_pht_idx  input  PHT_INDEX_WIDTH  index for untracked resolution.
REQ-020 SHALL have port o_underflow  output  1  sticky: tracked resolution with empty FIFO.

Function
REQ-021 SHALL hold PHT of 2^PHT_INDEX_WIDTH 2-bit saturating counters; taken iff counter >= 2.
REQ-022 SHALL compute o_pht_idx = i_pc[PHT_INDEX_WIDTH+1:2] XOR zero-extended speculative GHR, combinationally.
REQ-023 SHALL drive o_pred_taken = i_btb_hit & PHT[o_pht_idx][1], combinationally.
REQ-024 SHALL drive o_pred_pc = {i_pc[31:28], i_btb_target, 2'b00} when o_pred_taken, else i_pc + 4 (mod 2^32).
REQ-025 SHALL assert o_pred_tracked = i_fetch_valid & i_btb_hit & o_ready & ~(i_res_valid & i_res_mispredict).
REQ-026 On o_pred_tracked, SHALL push {o_pht_idx, o_pred_taken} and shift spec GHR left inserting o_pred_taken.
REQ-027 SHALL drive o_ready = FIFO count < CKPT_DEPTH; fetch holds i_pc while a BTB hit sees o_ready=0.
REQ-028 On i_res_valid & i_res_tracked with FIFO non-empty, SHALL pop head, update PHT at head index, shift committed GHR inserting i_res_taken.
REQ-029 On i_res_valid & ~i_res_tracked, SHALL update PHT at i_res_pht_idx; FIFO and GHRs unchanged.
REQ-030 PHT update SHALL be +1 if taken, -1 if not, saturating at 3 and 0.
REQ-031 On i_res_valid & i_res_mispredict, SHALL flush FIFO (count 0) and set spec GHR = committed GHR after this cycle's update.
REQ-032 Mispredict flush SHALL override a same-cycle push; the push is discarded.
REQ-033 Simultaneous push and pop without mispredict SHALL leave count unchanged, both take effect; push when full and pop same cycle is not permitted (o_ready=0).
REQ-034 Same-cycle read and update of same PHT entry SHALL return the pre-update value.
REQ-035 Tracked resolution with empty FIFO SHALL set o_underflow, leave PHT/GHR unchanged.
REQ-036 FIFO pointers SHALL wrap modulo CKPT_DEPTH.

Reset
REQ-037 On rst_n=0 at clk edge, SHALL set all PHT counters to 2'b01, both GHRs to 0, FIFO count/pointers to 0, o_underflow to 0.
REQ-038 Reset SHALL take priority over all concurrent push, pop and mispredict; reset mid-operation discards in-flight entries.
REQ-039 After reset o_ready=1, o_pred_taken=0, o_pred_tracked=0 for any input.

Verification
REQ-040 Reset, i_pc=0x00400010, hit, target 0x0100040 -> o_pred_taken=0, o_pred_pc=0x00400014, o_pht_idx=4, push.
REQ-041 Resolve tracked taken twice at idx 4 (GHR held 0) -> counter 01->10->11; next lookup predicts taken, o_pred_pc=0x00400100.
REQ-042 Four BTB-hit fetches without resolution -> count 4, o_ready=0, fifth o_pred_tracked=0; one tracked resolve -> o_ready=1.
REQ-043 Two tracked pushes (spec GHR=0b00), resolve first taken with mispredict plus same-cycle push -> FIFO empty, spec GHR=committed=0b000001, push dropped.
REQ-044 Counter at 11 resolved taken -> stays 11; counter at 00 resolved not-taken -> stays 00.
REQ-045 Tracked resolve with empty FIFO -> o_underflow=1 until rst_n=0.
